// File: rtl/cpu_sequencer.sv
// Instruction sequencer: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK, sticky TRAP.
// Optional fetch watchdog enabled by defining MMRV_FETCH_TIMEOUT_EN.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_word,
  output logic        dec_ce,
  input  logic        illegal,
  input  logic        regfile_we_in,
  input  logic        pc_in_sel,
  input  logic [31:0] pc_target,
  output logic        regfile_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cause_d;
  logic [31:0] pc_next;

`ifdef MMRV_FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] fetch_cnt;
  logic          timeout_hit;

  // Counts ack-less FETCH cycles; any other state re-arms it for the next fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                fetch_cnt <= '0;
    else if (state_q != S_FETCH) fetch_cnt <= '0;
    else if (!imem_ack)        fetch_cnt <= fetch_cnt + 1'b1;
  end

  assign timeout_hit = (fetch_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  assign pc_next = pc_in_sel ? (pc + 32'd4) : pc_target;

  always_comb begin
    state_d = state_q;
    cause_d = 2'd0;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
`ifdef MMRV_FETCH_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end
`endif
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else if (!pc_in_sel && (pc_target[1:0] != 2'b00)) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc         <= RESET_PC;
      instr_word <= '0;
      trap_cause <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ack) instr_word <= imem_rdata;
      if (state_q == S_WRITEBACK)         pc         <= pc_next;
      // Cause is captured only on trap entry so it stays frozen while trapped.
      if (state_q != S_TRAP && state_d == S_TRAP) trap_cause <= cause_d;
    end
  end

  assign state      = state_q;
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc;
  assign dec_ce     = (state_q == S_DECODE);
  assign halted     = (state_q == S_IDLE) || (state_q == S_TRAP);
  assign trap       = (state_q == S_TRAP);
  assign regfile_we = (state_q == S_WRITEBACK) && regfile_we_in;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboarded bench for cpu_sequencer: driver pushes per-instruction outcomes, negedge monitor checks them.
module tb_cpu_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_word;
  logic        dec_ce;
  logic        illegal = 1'b0;
  logic        regfile_we_in = 1'b0;
  logic        pc_in_sel = 1'b1;
  logic [31:0] pc_target = '0;
  logic        regfile_we;
  logic [31:0] pc;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  cpu_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_word(instr_word), .dec_ce(dec_ce), .illegal(illegal), .regfile_we_in(regfile_we_in),
    .pc_in_sel(pc_in_sel), .pc_target(pc_target), .regfile_we(regfile_we), .pc(pc),
    .halted(halted), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    bit          we;
    logic [1:0]  cause;
    logic [31:0] pc_after;
    logic [31:0] iw;
    int          decodes;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mpc = RST_PC;
  logic [31:0] miw = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: retirements and trap entries are popped against the scoreboard.
  logic [31:0] last_pc = RST_PC;
  logic [31:0] pend_pc = '0;
  logic [2:0]  prev_state = 3'd0;
  bit          prev_trap = 1'b0;
  int          dec_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_pc = RST_PC; prev_state = 3'd0; prev_trap = 1'b0; dec_cnt = 0;
    end else begin
      if (prev_state == 3'd4) chk("pc_after_wb", pc, pend_pc);
      else                    chk("pc_stable", pc, last_pc);
      if (dec_ce) dec_cnt++;
      if (state != 3'd4) chk("we_outside_wb", 32'(regfile_we), 32'd0);
      if (state == 3'd4) begin
        if (q.size() == 0) chk("unexpected_wb", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("wb_expected_kind", 32'(e.is_trap), 32'd0);
          chk("regfile_we", 32'(regfile_we), 32'(e.we));
          chk("wb_instr_word", instr_word, e.iw);
          chk("dec_ce_pulses", 32'(dec_cnt), 32'(e.decodes));
          pend_pc = e.pc_after;
        end
        dec_cnt = 0;
      end
      if (trap && !prev_trap) begin
        if (q.size() == 0) chk("unexpected_trap", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("trap_expected_kind", 32'(e.is_trap), 32'd1);
          chk("trap_cause", 32'(trap_cause), 32'(e.cause));
          chk("trap_pc", pc, e.pc_after);
          chk("trap_instr_word", instr_word, e.iw);
          chk("trap_dec_pulses", 32'(dec_cnt), 32'(e.decodes));
        end
        dec_cnt = 0;
      end
      prev_trap  = trap;
      prev_state = state;
      last_pc    = pc;
    end
  end

  // One instruction: the reference outcome comes straight from the architectural rules.
  task automatic do_instr(input int dly, input logic [31:0] rd, input bit ill_i, input bit sel_i,
                          input logic [31:0] tgt_i, input bit we_i, input bit drop_i);
    exp_t e;
    int n, reqs;
    logic [31:0] pc0;
    bit tr;
    pc0 = mpc;
    tr = ill_i || (!sel_i && (tgt_i[1:0] != 2'b00));
    e.is_trap = tr;
    e.cause   = ill_i ? 2'd1 : (tr ? 2'd2 : 2'd0);
    e.we      = we_i && !tr;
    e.iw      = rd;
    e.decodes = 1;
    if (!tr) mpc = sel_i ? mpc + 32'd4 : tgt_i;
    e.pc_after = mpc;
    miw = rd;
    q.push_back(e);
    illegal = ill_i; pc_in_sel = sel_i; pc_target = tgt_i; regfile_we_in = we_i; run = 1'b1;
    n = 0;
    while (state != 3'd1 && n < 8) begin @(posedge clk); #1; n++; end
    chk("reach_fetch", 32'(state), 32'd1);
    reqs = 0;
    for (int i = 0; i <= dly; i++) begin
      imem_ack   = (i == dly);
      imem_rdata = (i == dly) ? rd : $urandom;
      if (imem_req) reqs++;
      chk("fetch_addr", imem_addr, pc0);
      @(posedge clk); #1;
    end
    imem_ack = 1'b1; imem_rdata = $urandom;
    chk("req_cycles", 32'(reqs), 32'(dly + 1));
    chk("decode_state", 32'(state), 32'd2);
    chk("dec_ce", 32'(dec_ce), 32'd1);
    if (drop_i) run = 1'b0;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("execute_state", 32'(state), 32'd3);
    @(posedge clk); #1;
    chk("post_execute_state", 32'(state), tr ? 32'd5 : 32'd4);
    if (!tr) begin
      @(posedge clk); #1;
      chk("next_state", 32'(state), drop_i ? 32'd0 : 32'd1);
      if (drop_i) chk("halted_after_drop", 32'(halted), 32'd1);
    end
  endtask

  task automatic hold_trap(input logic [1:0] c);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom; run = 1'($urandom);
      illegal = 1'($urandom); pc_in_sel = 1'($urandom); pc_target = $urandom; regfile_we_in = 1'b1;
      @(posedge clk); #1;
      chk("trap_sticky_state", 32'(state), 32'd5);
      chk("trap_flag", 32'({trap, halted}), 32'd3);
      chk("trap_cause_frozen", 32'(trap_cause), 32'(c));
      chk("trap_iw_frozen", instr_word, miw);
      chk("trap_no_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    chk("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_iw", instr_word, 32'd0);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mpc = RST_PC; miw = '0;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc", pc, RST_PC);
    chk("reset_iw", instr_word, 32'd0);
    chk("reset_flags", 32'({halted, trap, trap_cause, imem_req, dec_ce, regfile_we}), 32'h40);
    rst_n = 1'b1;
    // Acks while idle must be ignored and nothing may start without run.
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
      @(posedge clk); #1;
      chk("idle_hold", 32'(state), 32'd0);
      chk("idle_iw", instr_word, 32'd0);
    end
    imem_ack = 1'b0;

    do_instr(0, 32'h1234_5037, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    chk("lui_pc", pc, 32'h4);
    do_instr(5, $urandom, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    do_instr(int'($urandom_range(0, 3)), $urandom, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++)
      do_instr(int'($urandom_range(0, 3)), $urandom, 1'b0, 1'($urandom), $urandom & 32'hFFFF_FFFC,
               1'($urandom), ($urandom_range(0, 4) == 0));
    do_instr(1, $urandom, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0);
    do_instr(0, $urandom, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    chk("wrap_pc", pc, 32'h0);

    do_instr(2, $urandom, 1'b0, 1'b0, 32'h102, 1'b1, 1'b0);
    hold_trap(2'd2);
    pulse_reset();

    do_instr(0, $urandom, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    do_instr(1, $urandom, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
    hold_trap(2'd1);
    pulse_reset();
    chk("post_trap_reset_state", 32'(state), 32'd0);

    // Fetch with no ack ever arriving.
    run = 1'b1; imem_ack = 1'b0; pc_in_sel = 1'b1; illegal = 1'b0;
    @(posedge clk); #1;
    chk("fetch_entry", 32'(state), 32'd1);
`ifdef MMRV_FETCH_TIMEOUT_EN
    e.is_trap = 1'b1; e.we = 1'b0; e.cause = 2'd3; e.pc_after = mpc; e.iw = miw; e.decodes = 0;
    q.push_back(e);
    repeat (15) begin @(posedge clk); #1; end
    chk("timeout_last_fetch", 32'(state), 32'd1);
    @(posedge clk); #1;
    chk("timeout_trap", 32'(state), 32'd5);
    chk("timeout_cause", 32'(trap_cause), 32'd3);
`else
    repeat (100) begin @(posedge clk); #1; end
    chk("no_timeout_state", 32'(state), 32'd1);
    chk("no_timeout_req", 32'(imem_req), 32'd1);
`endif
    run = 1'b0;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
      @(posedge clk); #1;
      chk("after_reset_ack_ignored", instr_word, 32'd0);
      chk("after_reset_idle", 32'(state), 32'd0);
    end
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    chk("queue_empty_end", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, FETCH cycles without ack before trap (used only with MMRV_FETCH_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port run  input  1  enable instruction sequencing.
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-008 SHALL have port imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port instr_word  output  32  latched instruction register, drives decoder.
REQ-011 SHALL have port dec_ce  output  1  decoder enable, one-cycle pulse.
REQ-012 SHALL have port illegal  input  1  decoder flag: unsupported opcode.
REQ-013 SHALL have port regfile_we_in  input  1  decoder write-enable request.
REQ-014 SHALL have port pc_in_sel  input  1  0 = take pc_target, 1 = pc+4.
REQ-015 SHALL have port pc_target  input  32  jump target from datapath.
REQ-016 SHALL have port regfile_we  output  1  gated register-file write enable.
REQ-017 SHALL have port pc  output  32  current program counter.
REQ-018 SHALL have port halted  output  1  high in IDLE or TRAP.
REQ-019 SHALL have port trap  output  1  high in TRAP.
REQ-020 SHALL have port trap_cause  output  2  0 none, 1 illegal, 2 misaligned target, 3 fetch timeout.
REQ-021 SHALL have port state  output  3  debug: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 WRITEBACK=4 TRAP=5.

Function
REQ-022 SHALL be a Moore FSM; imem_req, dec_ce, halted, trap decoded from registered state only.
REQ-023 IDLE: when run=1, next state FETCH; otherwise stay.
REQ-024 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack latch imem_rdata into instr_word, go DECODE.
REQ-025 imem_ack outside FETCH SHALL be ignored; instr_word unchanged.
REQ-026 DECODE: dec_ce=1 for exactly one cycle, then EXECUTE.
REQ-027 EXECUTE: illegal=1 -> TRAP, cause 1; pc_in_sel=0 with pc_target[1:0]!=0 -> TRAP, cause 2; else WRITEBACK.
REQ-028 WRITEBACK: regfile_we=regfile_we_in for this cycle only; pc <= pc_target if pc_in_sel=0 else pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-029 After WRITEBACK: run=1 -> FETCH, run=0 -> IDLE.
REQ-030 run deasserted mid-instruction SHALL NOT abort; current instruction completes, then IDLE.
REQ-031 regfile_we SHALL be 0 in every state except WRITEBACK; pc SHALL change only in WRITEBACK.
REQ-032 TRAP is sticky: pc, instr_word, trap_cause frozen; exit only via reset.
REQ-033 Minimum latency: 4 cycles per instruction when imem_ack arrives in first FETCH cycle.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, instr_word=0, trap_cause=0, fetch counter=0, regardless of clk.
REQ-035 Reset asserted mid-fetch SHALL drop imem_req at once; a subsequent ack SHALL be ignored.
REQ-036 After reset release, first FETCH occurs no earlier than the first edge with run=1.

Configuration
REQ-037 With MMRV_FETCH_TIMEOUT_EN defined, a counter SHALL count consecutive FETCH cycles without ack; on reaching TIMEOUT_CYCLES, next state TRAP, cause 3; counter clears on entering FETCH.
REQ-038 Without MMRV_FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, no counter logic, cause 3 never produced, TIMEOUT_CYCLES ignored.

Verification
REQ-039 Reset, run=1, ack on first req cycle, rdata=0x12345037 (LUI), regfile_we_in=1, pc_in_sel=1 -> regfile_we pulse in cycle 4, pc 0x0->0x4, back in FETCH cycle 5.
REQ-040 Ack delayed 5 cycles -> imem_req high 6 cycles, imem_addr stable, dec_ce exactly one pulse.
REQ-041 pc_in_sel=0, pc_target=0x100 -> pc=0x100; pc_target=0x102 -> trap=1, trap_cause=2, pc unchanged, no regfile_we.
REQ-042 illegal=1 in EXECUTE -> trap=1, cause=1, state=5 held for 20 cycles; rst_n pulse -> state=0, pc=RESET_PC.
REQ-043 run dropped during DECODE -> instruction completes WRITEBACK, then IDLE, halted=1; pc=0xFFFFFFFC with pc+4 -> pc=0.
REQ-044 MMRV_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> TRAP cause 3 after 16 FETCH cycles; macro undefined -> still FETCH after 100 cycles.
